lrf_out_stage: RTL and testbench
================================

# lrf_out_stage

Output stage of the LRF fusion core: takes the per-beat fused-pixel stream leaving the FUSION stage, keeps only the beats of the last frame in each fusion group (the completed fused image), buffers them in a small FIFO, and presents them on an AXI4-Stream master with `tlast` on the final beat of each image. It also returns a stall/ready indication upstream, so the datapath stops advancing before the FIFO overflows.

## Interface
Parameters:
- `PIXELS_PER_BEAT`, 16, pixels per beat (8 bit each)
- `IMAGE_DIM`, 512, image width = height in pixels
- `N_FUSE_COUNT`, 4, log2 of frames fused per output image
- `FIFO_DEPTH`, 8, output FIFO entries; power of two, ≥4
- `DATA_WIDTH`, 8*PIXELS_PER_BEAT, beat width

Ports:
- `s_axis_aclk`  in  1  sole clock
- `s_axis_areset`  in  1  asynchronous, active-high reset
- `in_tdata`  in  DATA_WIDTH  fused beat from FUSION stage
- `in_tvalid`  in  1  beat valid; a beat is consumed every cycle it is high
- `in_ready`  out  1  upstream may advance (FIFO has ≥2 free entries)
- `m_axis_tdata`  out  DATA_WIDTH  output beat
- `m_axis_tvalid`  out  1  output valid
- `m_axis_tready`  in  1  downstream ready
- `m_axis_tlast`  out  1  last beat of output image
- `frame_done`  out  1  one-cycle pulse when the tlast beat handshakes
- `overflow`  out  1  sticky: a kept beat was dropped

## Operation
- Constants: BEATS = IMAGE_DIM²/PIXELS_PER_BEAT; FUSE = 2^N_FUSE_COUNT.
- `beat_cnt` (clog2 BEATS bits) increments on every `in_tvalid`; wraps BEATS-1→0, and on wrap `frame_cnt` (N_FUSE_COUNT bits) increments, wrapping FUSE-1→0.
- Keep = `in_tvalid` && `frame_cnt`==FUSE-1. Non-kept beats are counted and discarded.
- Kept beat pushes {tlast, tdata} with tlast = (`beat_cnt`==BEATS-1).
- Push succeeds if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs in the same cycle. Otherwise the beat is dropped, `overflow` is set and stays set until reset; the counters still advance.
- Pop = `m_axis_tvalid` && `m_axis_tready`. The head entry drives `m_axis_*`; `m_axis_tvalid` = (count≠0), from a register.
- AXI rule: once `m_axis_tvalid` rises, tdata/tlast stay stable and tvalid stays high until the handshake.
- `in_ready` = (count ≤ FIFO_DEPTH-2), combinational from the registered count.
- `frame_done` is registered: high the cycle after a pop with tlast=1.

## Timing
- Reset (async assert, sync-released use): beat_cnt=0, frame_cnt=0, FIFO empty, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `frame_done`=0, `overflow`=0, `in_ready`=1.
- Reset mid-frame discards buffered beats and restarts counting at frame 0, beat 0.
- Latency: a kept beat pushed into an empty FIFO at edge t is valid on `m_axis_*` after edge t (first-word fall-through, one register).
- Throughput: one beat per cycle with `m_axis_tready` held high.
- Simultaneous push and pop at count==FIFO_DEPTH: the count holds and no overflow occurs.
- Count wraps for pointers mod FIFO_DEPTH; the count register is clog2(FIFO_DEPTH)+1 bits.

## Structure
- The shared package `lrf_pkg` holds the BEATS/FUSE derivations and the counter-width functions (clog2 based), reused by LSU and the top level.
- One sub-module, `lrf_sync_fifo`: parameterised width/depth, FWFT, with push/pop/count/full/empty. The frame/beat counters, keep logic, overflow and `frame_done` stay in `lrf_out_stage`.
- Top level: the LRF core drives `in_tdata` from the FUSION output and gates `step` with `in_ready`.

## Test plan
Use IMAGE_DIM=8, PIXELS_PER_BEAT=16 (BEATS=4), N_FUSE_COUNT=2 (FUSE=4) and FIFO_DEPTH=4 unless noted.
- Stream 16 beats with data=index, `m_axis_tready`=1 → only beats 12..15 are emitted, one cycle after input, with tlast on 15 and a `frame_done` pulse one cycle after it.
- Same stream with `m_axis_tready`=0 during frame 3, released after → beats 12..15 are held stable and in order; `in_ready` drops after 3 entries; `overflow`=0 once upstream honours `in_ready`.
- Ignore `in_ready`: push 6 kept beats with `m_axis_tready`=0 → the FIFO holds beats 12..15, `overflow`=1 and stays set.
- Full FIFO, push and pop in the same cycle → count stays 4, `overflow`=0, and the new beat appears after the three older ones.
- Assert `s_axis_areset` mid frame 3 with 2 beats buffered → `m_axis_tvalid`=0 immediately; the next 16 input beats again emit only beats 12..15.
- Run 2 full groups (32 beats) back-to-back → 8 output beats with tlast on output beats 4 and 8, and 2 `frame_done` pulses.

Source files
------------

// File: rtl/lrf_pkg.sv
// Shared derivations for the LRF core: beats per image, frames per fusion
// group and the counter widths that follow from them.
package lrf_pkg;

  // Beats needed to carry one square image of dim x dim 8-bit pixels.
  function automatic int calc_beats(input int image_dim, input int pixels_per_beat);
    return (image_dim * image_dim) / pixels_per_beat;
  endfunction

  // Number of frames fused into one output image.
  function automatic int calc_fuse(input int n_fuse_count);
    return 1 << n_fuse_count;
  endfunction

  // Width of a counter running 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Occupancy counter width: must be able to hold the value 'depth' itself.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lrf_sync_fifo.sv
// First-word fall-through FIFO. The head entry is presented as soon as it
// is written; valid (not empty) comes straight from a register so the
// downstream handshake never sees a combinational path from push.
module lrf_sync_fifo
  import lrf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_i,
  input  logic [WIDTH-1:0]                 push_data_i,
  input  logic                             pop_i,
  output logic [WIDTH-1:0]                 head_o,
  output logic [fifo_cnt_width(DEPTH)-1:0] count_o,
  output logic                             full_o,
  output logic                             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = !valid_q;
  assign count_o = count_q;
  // A pop is only real when something is there; a push into a full FIFO
  // is accepted only when the head leaves in the same cycle.
  assign pop_ok  = pop_i && valid_q;
  assign push_ok = push_i && (!full_o || pop_ok);
  // Zero the bus while empty so stale slots never show on the output.
  assign head_o  = valid_q ? mem_q[rd_ptr_q] : '0;

  // Next-state for pointers, occupancy and the registered valid flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
    valid_d = (count_d != '0);
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/lrf_out_stage.sv
// Output stage of the LRF fusion core. Tracks beat/frame position of the
// fused stream, keeps only the last frame of every fusion group, buffers it
// and drives it out as AXI4-Stream with tlast on the final beat of each image.
module lrf_out_stage
  import lrf_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int N_FUSE_COUNT    = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_areset,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int BEATS  = calc_beats(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int FUSE   = calc_fuse(N_FUSE_COUNT);
  localparam int BEAT_W = cnt_width(BEATS);
  localparam int CW     = fifo_cnt_width(FIFO_DEPTH);

  localparam logic [BEAT_W-1:0]       BEAT_LAST  = BEAT_W'(BEATS - 1);
  localparam logic [N_FUSE_COUNT-1:0] FRAME_LAST = N_FUSE_COUNT'(FUSE - 1);

  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [N_FUSE_COUNT-1:0] frame_cnt_q, frame_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    frame_done_q, frame_done_d;

  logic                    keep, pop, drop, beat_wrap;
  logic [DATA_WIDTH:0]     push_data, head;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_full, fifo_empty;

  assign beat_wrap = (beat_cnt_q == BEAT_LAST);
  assign keep      = in_tvalid && (frame_cnt_q == FRAME_LAST);
  assign push_data = {beat_wrap, in_tdata};
  assign pop       = m_axis_tvalid && m_axis_tready;
  // Mirrors the FIFO's own acceptance rule: full with no departing head.
  assign drop      = keep && fifo_full && !pop;

  lrf_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (s_axis_aclk),
    .rst         (s_axis_areset),
    .push_i      (keep),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign {m_axis_tlast, m_axis_tdata} = head;
  assign m_axis_tvalid = !fifo_empty;
  // Two free slots of headroom cover the beat already in flight upstream.
  assign in_ready      = (fifo_count <= CW'(FIFO_DEPTH - 2));
  assign overflow      = overflow_q;
  assign frame_done    = frame_done_q;

  // Stream position tracking, sticky drop flag and end-of-image pulse.
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    overflow_d   = overflow_q || drop;
    frame_done_d = pop && m_axis_tlast;
    if (in_tvalid) begin
      if (beat_wrap) begin
        beat_cnt_d  = '0;
        frame_cnt_d = frame_cnt_q + 1'b1;
      end else begin
        beat_cnt_d  = beat_cnt_q + 1'b1;
      end
    end
  end

  // Control state register.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      beat_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_lrf_out_stage.sv
// Bench for lrf_out_stage: a reference model of the beat/frame counters and
// FIFO occupancy feeds a queue of expected output beats; a table of stream
// scenarios plus hand-written corner sequences drive the stimulus.
module tb_lrf_out_stage;

  localparam int PPB   = 16;
  localparam int DIM   = 8;
  localparam int NF    = 2;
  localparam int DEPTH = 4;
  localparam int DW    = 8 * PPB;
  localparam int BEATS = DIM * DIM / PPB;
  localparam int FUSE  = 1 << NF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_tdata = '0;
  logic          in_tvalid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          frame_done;
  logic          overflow;

  always #5 clk = ~clk;

  lrf_out_stage #(
    .PIXELS_PER_BEAT (PPB),
    .IMAGE_DIM       (DIM),
    .N_FUSE_COUNT    (NF),
    .FIFO_DEPTH      (DEPTH),
    .DATA_WIDTH      (DW)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .in_tdata      (in_tdata),
    .in_tvalid     (in_tvalid),
    .in_ready      (in_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    int nbeats;
    int mode;      // 0: tready high, 1: stall in frame 3, 2: tready low throughout
    bit honor;     // upstream respects in_ready
    int exp_emit;
    int exp_done;
    bit exp_ovf;
  } vec_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mbeat, mframe, act_emit, act_done;
  bit   movf, exp_fd;

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle between clock edges.
  always @(negedge clk) begin
    bit   pop, keep, push;
    exp_t e;
    if (rst) begin
      q.delete();
      mbeat = 0; mframe = 0; movf = 0; exp_fd = 0;
      act_emit = 0; act_done = 0;
    end else begin
      chk("tvalid", m_axis_tvalid, q.size() != 0);
      chk("in_ready", in_ready, q.size() <= DEPTH - 2);
      chk("overflow", overflow, movf);
      chk("frame_done", frame_done, exp_fd);
      if (q.size() != 0) begin
        chk("tdata", m_axis_tdata, q[0].data);
        chk("tlast", m_axis_tlast, q[0].last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        act_emit++;
        $display("out beat data=%0d last=%0b", m_axis_tdata, m_axis_tlast);
      end
      if (frame_done) act_done++;
      pop    = (q.size() != 0) && m_axis_tready;
      exp_fd = pop && q[0].last;
      keep   = in_tvalid && (mframe == FUSE - 1);
      push   = keep && ((q.size() < DEPTH) || pop);
      if (keep && !push) movf = 1;
      e.last = (mbeat == BEATS - 1);
      e.data = in_tdata;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
      if (in_tvalid) begin
        if (mbeat == BEATS - 1) begin
          mbeat  = 0;
          mframe = (mframe + 1) % FUSE;
        end else begin
          mbeat++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_tvalid     = 1'b0;
    m_axis_tready = 1'b1;
    rst           = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_stream(input int nbeats, input int mode, input bit honor);
    int idx   = 0;
    int hold  = 0;
    int guard = 0;
    while (idx < nbeats && guard < 1000) begin
      guard++;
      case (mode)
        1: begin
          if (idx >= 12 && hold < 8) begin
            m_axis_tready = 1'b0;
            hold++;
          end else begin
            m_axis_tready = 1'b1;
          end
        end
        2:       m_axis_tready = 1'b0;
        default: m_axis_tready = 1'b1;
      endcase
      if (honor && !in_ready) begin
        in_tvalid = 1'b0;
      end else begin
        in_tvalid = 1'b1;
        in_tdata  = DW'(idx);
        idx++;
      end
      tick();
    end
    in_tvalid = 1'b0;
    chk("stream_timeout", idx, nbeats);
  endtask

  task automatic drain();
    int i;
    in_tvalid     = 1'b0;
    m_axis_tready = 1'b1;
    for (i = 0; i < 100; i++) begin
      if (q.size() == 0 && !m_axis_tvalid) break;
      tick();
    end
    chk("drain_timeout", m_axis_tvalid, 0);
    repeat (3) tick();
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{nbeats: 16, mode: 0, honor: 1, exp_emit: 4, exp_done: 1, exp_ovf: 0};
    vecs[1] = '{nbeats: 16, mode: 1, honor: 1, exp_emit: 4, exp_done: 1, exp_ovf: 0};
    vecs[2] = '{nbeats: 30, mode: 2, honor: 0, exp_emit: 4, exp_done: 1, exp_ovf: 1};
    vecs[3] = '{nbeats: 32, mode: 0, honor: 1, exp_emit: 8, exp_done: 2, exp_ovf: 0};

    // Reset state, sampled while reset is still asserted.
    repeat (2) tick();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_ready", in_ready, 1);

    foreach (vecs[v]) begin
      do_reset();
      run_stream(vecs[v].nbeats, vecs[v].mode, vecs[v].honor);
      drain();
      chk("emitted", act_emit, vecs[v].exp_emit);
      chk("done_pulses", act_done, vecs[v].exp_done);
      chk("ovf_final", overflow, vecs[v].exp_ovf);
      $display("vector %0d: emitted=%0d done=%0d overflow=%0b", v, act_emit, act_done, overflow);
    end

    // Full FIFO with a push and a pop on the same edge.
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 28; i++) begin
      in_tvalid = 1'b1;
      in_tdata  = DW'(i);
      tick();
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_head", m_axis_tdata, 12);
    in_tdata      = DW'(28);
    m_axis_tready = 1'b1;
    tick();
    in_tvalid     = 1'b0;
    m_axis_tready = 1'b0;
    tick();
    chk("pp_overflow", overflow, 0);
    chk("pp_in_ready", in_ready, 0);
    chk("pp_tvalid", m_axis_tvalid, 1);
    chk("pp_head", m_axis_tdata, 13);
    drain();
    chk("pp_emitted", act_emit, 5);
    chk("pp_done", act_done, 1);
    $display("push/pop at full: emitted=%0d overflow=%0b", act_emit, overflow);

    // Reset mid frame 3 with two beats buffered.
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      in_tvalid = 1'b1;
      in_tdata  = DW'(i);
      tick();
    end
    in_tvalid = 1'b0;
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_tdata", m_axis_tdata, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    run_stream(16, 0, 1);
    drain();
    chk("post_rst_emitted", act_emit, 4);
    chk("post_rst_done", act_done, 1);
    $display("after mid-frame reset: emitted=%0d done=%0d", act_emit, act_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
